// File: rtl/regq_univ.sv
// Universal Q register: parallel load, bidirectional shift with selectable fill,
// registered shift-out bit and a saturating shift counter with completion flag.
module regq_univ #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             CargaQ,
   input  logic             DesplazaQ,
   input  logic             dir,
   input  logic [1:0]       modo,
   input  logic             sin,
   input  logic [WIDTH-1:0] entQ,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic [CW-1:0]    cuenta,
   output logic             fin
);

   typedef enum logic [1:0] {
      FILL_ZERO   = 2'b00,
      FILL_SERIAL = 2'b01,
      FILL_ARITH  = 2'b10,
      FILL_ROTATE = 2'b11
   } fill_e;

   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   fill_e            mode;
   logic             fill;
   logic             out_bit;
   logic [WIDTH-1:0] q_next;

   assign mode = fill_e'(modo);

   // Arithmetic fill replicates the sign on right shifts but degenerates to zero on left shifts.
   always_comb begin
      fill    = 1'b0;
      out_bit = 1'b0;
      q_next  = q;
      if (!dir) begin
         unique case (mode)
            FILL_ZERO:   fill = 1'b0;
            FILL_SERIAL: fill = sin;
            FILL_ARITH:  fill = q[WIDTH-1];
            FILL_ROTATE: fill = q[0];
         endcase
         q_next  = {fill, q[WIDTH-1:1]};
         out_bit = q[0];
      end else begin
         unique case (mode)
            FILL_ZERO:   fill = 1'b0;
            FILL_SERIAL: fill = sin;
            FILL_ARITH:  fill = 1'b0;
            FILL_ROTATE: fill = q[WIDTH-1];
         endcase
         q_next  = {q[WIDTH-2:0], fill};
         out_bit = q[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q      <= '0;
         sout   <= 1'b0;
         cuenta <= '0;
      end else if (CargaQ) begin
         q      <= entQ;
         sout   <= 1'b0;
         cuenta <= '0;
      end else if (DesplazaQ) begin
         q    <= q_next;
         sout <= out_bit;
         if (cuenta < FULL) begin
            cuenta <= cuenta + CW'(1);
         end
      end
   end

   assign fin = (cuenta == FULL);

endmodule

// File: tb/tb_regq_univ.sv
// Bench for regq_univ: directed vector table on WIDTH=4, a WIDTH=8 completion
// sequence, and randomized traffic on both widths against an arithmetic model.
module tb_regq_univ;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       CargaQ = 1'b0;
   logic       DesplazaQ = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] modo = 2'b00;
   logic       sin = 1'b0;
   logic [3:0] ent4 = '0;
   logic [7:0] ent8 = '0;

   logic [3:0] q4;
   logic       sout4;
   logic [2:0] cuenta4;
   logic       fin4;
   logic [7:0] q8;
   logic       sout8;
   logic [3:0] cuenta8;
   logic       fin8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regq_univ #(.WIDTH(4)) u4 (
      .clk(clk), .reset(reset), .CargaQ(CargaQ), .DesplazaQ(DesplazaQ),
      .dir(dir), .modo(modo), .sin(sin), .entQ(ent4),
      .q(q4), .sout(sout4), .cuenta(cuenta4), .fin(fin4)
   );

   regq_univ #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .CargaQ(CargaQ), .DesplazaQ(DesplazaQ),
      .dir(dir), .modo(modo), .sin(sin), .entQ(ent8),
      .q(q8), .sout(sout8), .cuenta(cuenta8), .fin(fin8)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit       rst;
      bit       ld;
      bit       sh;
      bit       d;
      bit [1:0] m;
      bit       si;
      bit [3:0] ent;
      bit [3:0] eq;
      bit       es;
      int       ec;
      bit       ef;
   } vec_t;

   function automatic vec_t v(bit rst, bit ld, bit sh, bit d, bit [1:0] m, bit si,
                              bit [3:0] ent, bit [3:0] eq, bit es, int ec, bit ef);
      vec_t r;
      r.rst = rst; r.ld = ld; r.sh = sh; r.d = d; r.m = m; r.si = si;
      r.ent = ent; r.eq = eq; r.es = es; r.ec = ec; r.ef = ef;
      return r;
   endfunction

   // Reference: the register as an integer, shifts as multiply/divide by two.
   task automatic model(input int w, input bit rst, input bit ld, input bit sh,
                        input bit d, input bit [1:0] m, input bit si, input int ent,
                        inout int mq, inout int ms, inout int mc);
      int msb, lsb, fill, top;
      top = 1 << (w - 1);
      msb = (mq / top) % 2;
      lsb = mq % 2;
      if (rst) begin
         mq = 0; ms = 0; mc = 0;
      end else if (ld) begin
         mq = ent; ms = 0; mc = 0;
      end else if (sh) begin
         if (!d) begin
            case (m)
               2'd0: fill = 0;
               2'd1: fill = int'(si);
               2'd2: fill = msb;
               default: fill = lsb;
            endcase
            ms = lsb;
            mq = mq / 2 + fill * top;
         end else begin
            case (m)
               2'd1: fill = int'(si);
               2'd3: fill = msb;
               default: fill = 0;
            endcase
            ms = msb;
            mq = (mq * 2) % (2 * top) + fill;
         end
         if (mc < w) mc = mc + 1;
      end
   endtask

   task automatic drive(input bit rst, input bit ld, input bit sh, input bit d,
                        input bit [1:0] m, input bit si);
      reset = rst; CargaQ = ld; DesplazaQ = sh; dir = d; modo = m; sin = si;
   endtask

   vec_t tbl[$];
   int   mq4, ms4, mc4, mq8, ms8, mc8;

   initial begin
      // rst ld sh dir modo sin ent  | q sout cuenta fin
      tbl.push_back(v(1,0,0,0,2'b00,0,4'b0000, 4'b0000,0,0,0));
      tbl.push_back(v(0,0,0,0,2'b00,0,4'b0000, 4'b0000,0,0,0));
      tbl.push_back(v(0,0,0,0,2'b00,0,4'b0000, 4'b0000,0,0,0));
      tbl.push_back(v(0,0,0,0,2'b00,0,4'b0000, 4'b0000,0,0,0));
      tbl.push_back(v(0,1,0,0,2'b00,0,4'b1011, 4'b1011,0,0,0));
      tbl.push_back(v(0,0,1,0,2'b00,0,4'b0000, 4'b0101,1,1,0));
      tbl.push_back(v(0,0,1,0,2'b00,0,4'b0000, 4'b0010,1,2,0));
      tbl.push_back(v(0,0,1,0,2'b00,0,4'b0000, 4'b0001,0,3,0));
      tbl.push_back(v(0,0,1,0,2'b00,0,4'b0000, 4'b0000,1,4,1));
      tbl.push_back(v(0,0,1,0,2'b00,0,4'b0000, 4'b0000,0,4,1));
      tbl.push_back(v(0,1,0,0,2'b00,0,4'b1000, 4'b1000,0,0,0));
      tbl.push_back(v(0,0,1,0,2'b10,0,4'b0000, 4'b1100,0,1,0));
      tbl.push_back(v(0,0,1,0,2'b10,0,4'b0000, 4'b1110,0,2,0));
      tbl.push_back(v(0,1,0,0,2'b00,0,4'b1001, 4'b1001,0,0,0));
      tbl.push_back(v(0,0,1,1,2'b10,1,4'b0000, 4'b0010,1,1,0));
      tbl.push_back(v(0,1,0,0,2'b00,0,4'b1001, 4'b1001,0,0,0));
      tbl.push_back(v(0,0,1,1,2'b11,0,4'b0000, 4'b0011,1,1,0));
      tbl.push_back(v(0,0,1,1,2'b11,0,4'b0000, 4'b0110,0,2,0));
      tbl.push_back(v(0,0,1,1,2'b11,0,4'b0000, 4'b1100,0,3,0));
      tbl.push_back(v(0,0,1,1,2'b11,0,4'b0000, 4'b1001,1,4,1));
      tbl.push_back(v(0,1,0,0,2'b00,0,4'b1001, 4'b1001,0,0,0));
      tbl.push_back(v(0,0,1,0,2'b11,0,4'b0000, 4'b1100,1,1,0));
      tbl.push_back(v(0,1,0,0,2'b00,0,4'b0000, 4'b0000,0,0,0));
      tbl.push_back(v(0,0,1,1,2'b01,1,4'b0000, 4'b0001,0,1,0));
      tbl.push_back(v(0,0,1,1,2'b01,0,4'b0000, 4'b0010,0,2,0));
      tbl.push_back(v(0,0,1,1,2'b01,1,4'b0000, 4'b0101,0,3,0));
      tbl.push_back(v(0,0,1,1,2'b01,1,4'b0000, 4'b1011,0,4,1));
      tbl.push_back(v(0,1,1,1,2'b11,1,4'b0110, 4'b0110,0,0,0));
      tbl.push_back(v(0,0,0,1,2'b11,1,4'b1111, 4'b0110,0,0,0));
      tbl.push_back(v(1,1,0,0,2'b00,0,4'b1111, 4'b0000,0,0,0));
      tbl.push_back(v(0,0,1,0,2'b01,1,4'b0000, 4'b1000,0,1,0));
      tbl.push_back(v(1,0,1,0,2'b01,1,4'b0000, 4'b0000,0,0,0));

      @(negedge clk);
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].ld, tbl[i].sh, tbl[i].d, tbl[i].m, tbl[i].si);
         ent4 = tbl[i].ent;
         @(posedge clk); #1;
         check($sformatf("vec%0d_q", i),      int'(q4),      int'(tbl[i].eq));
         check($sformatf("vec%0d_sout", i),   int'(sout4),   int'(tbl[i].es));
         check($sformatf("vec%0d_cuenta", i), int'(cuenta4), tbl[i].ec);
         check($sformatf("vec%0d_fin", i),    int'(fin4),    int'(tbl[i].ef));
      end

      // Reset pulse between edges must not disturb state.
      drive(0, 1, 0, 0, 2'b00, 0);
      ent4 = 4'b1101;
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 2'b00, 0);
      #2 reset = 1'b1;
      #2 check("async_rst_q", int'(q4), 13);
      reset = 1'b0;
      @(posedge clk); #1;
      check("async_rst_hold_q", int'(q4), 13);

      // WIDTH=8 completion: fin only after the 8th shift.
      drive(0, 1, 0, 0, 2'b00, 0);
      ent8 = 8'hA5;
      @(posedge clk); #1;
      for (int k = 1; k <= 8; k++) begin
         drive(0, 0, 1, 0, 2'b00, 0);
         @(posedge clk); #1;
         check($sformatf("w8_shift%0d_q", k), int'(q8), 'hA5 >> k);
         check($sformatf("w8_shift%0d_cuenta", k), int'(cuenta8), k);
         check($sformatf("w8_shift%0d_fin", k), int'(fin8), (k == 8) ? 1 : 0);
      end
      drive(0, 1, 0, 0, 2'b00, 0);
      @(posedge clk); #1;
      check("w8_reload_fin", int'(fin8), 0);

      // Randomized traffic on both widths.
      drive(1, 0, 0, 0, 2'b00, 0);
      @(posedge clk); #1;
      mq4 = 0; ms4 = 0; mc4 = 0; mq8 = 0; ms8 = 0; mc8 = 0;
      for (int n = 0; n < 600; n++) begin
         bit r, l, s, d, si;
         bit [1:0] m;
         r  = ($urandom_range(0, 39) == 0);
         l  = ($urandom_range(0, 11) == 0);
         s  = ($urandom_range(0, 3) != 0);
         d  = 1'($urandom);
         m  = 2'($urandom);
         si = 1'($urandom);
         drive(r, l, s, d, m, si);
         ent4 = 4'($urandom);
         ent8 = 8'($urandom);
         model(4, r, l, s, d, m, si, int'(ent4), mq4, ms4, mc4);
         model(8, r, l, s, d, m, si, int'(ent8), mq8, ms8, mc8);
         @(posedge clk); #1;
         check("rnd4_q", int'(q4), mq4);
         check("rnd4_sout", int'(sout4), ms4);
         check("rnd4_cuenta", int'(cuenta4), mc4);
         check("rnd4_fin", int'(fin4), (mc4 == 4) ? 1 : 0);
         check("rnd8_q", int'(q8), mq8);
         check("rnd8_sout", int'(sout8), ms8);
         check("rnd8_cuenta", int'(cuenta8), mc8);
         check("rnd8_fin", int'(fin8), (mc8 == 8) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
